// File: rtl/register_bank_pkg.sv
// Shared datapath definitions: widths, architectural register indices and
// the stack-pointer reset value used by the destination select and the register bank.
package datapath_defs;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  localparam logic [DATA_WIDTH-1:0] SP_INIT_DEFAULT = 32'h0000_03FC;

endpackage

// File: rtl/register_bank_read_port.sv
// One combinational read port: index decode, $0 zero-force and optional
// write-first forwarding from the in-flight write.
module regbank_read_port
  import datapath_defs::*;
#(
  parameter int unsigned DATA_WIDTH = datapath_defs::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = datapath_defs::ADDR_WIDTH,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      read_reg,
  input  logic                                       fwd_en,
  input  logic [ADDR_WIDTH-1:0]                      write_reg,
  input  logic [DATA_WIDTH-1:0]                      write_data,
  output logic [DATA_WIDTH-1:0]                      read_data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  // Matching on read_reg != $0 also covers the write_reg != $0 forwarding rule.
  always_comb begin
    read_data = '0;
    if (read_reg != ZERO_IDX) begin
      if (BYPASS && fwd_en && (write_reg == read_reg))
        read_data = write_data;
      else
        read_data = regs[read_reg];
    end
  end

endmodule

// File: rtl/register_bank.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port, $0 hardwired to zero, $29 resets to SP_INIT.
module register_bank
  import datapath_defs::*;
#(
  parameter int unsigned            DATA_WIDTH = datapath_defs::DATA_WIDTH,
  parameter int unsigned            ADDR_WIDTH = datapath_defs::ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  SP_INIT    = DATA_WIDTH'(SP_INIT_DEFAULT),
  parameter bit                     BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  write_ack
);

  localparam int unsigned           NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] SP_IDX   = ADDR_WIDTH'(REG_SP);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic                                wr_commit;
  logic                                fwd_en;

  assign wr_commit = reg_write && (write_reg != ZERO_IDX);

  // While reset is held the array already shows reset contents, so forwarding
  // is suppressed to keep reads consistent with the discarded write.
  assign fwd_en = reg_write && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++)
        regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
      write_ack <= 1'b0;
    end else begin
      write_ack <= wr_commit;
      if (wr_commit)
        regs[write_reg] <= write_data;
    end
  end

  regbank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port1 (
    .regs       (regs),
    .read_reg   (read_reg1),
    .fwd_en     (fwd_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data1)
  );

  regbank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port2 (
    .regs       (regs),
    .read_reg   (read_reg2),
    .fwd_en     (fwd_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data2)
  );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: a forwarding and a non-forwarding register bank share
// one stimulus stream and are compared against a simple array model.
module tb_register_bank;

  localparam logic [31:0] SP_INIT = 32'h0000_03FC;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        ack_b, ack_n;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [32];

  register_bank #(.SP_INIT(SP_INIT), .BYPASS(1'b1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (rd1_b),
    .read_data2 (rd2_b),
    .write_ack  (ack_b)
  );

  register_bank #(.SP_INIT(SP_INIT), .BYPASS(1'b0)) dut_n (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (rd1_n),
    .read_data2 (rd2_n),
    .write_ack  (ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = (i == 29) ? SP_INIT : 32'h0;
  endfunction

  // Value a read port should show right now, given the pending write inputs.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit fwd);
    if (idx == 5'd0) return 32'h0;
    if (fwd && reg_write && !rst && write_reg == idx) return write_data;
    return model_mem[idx];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write = we; write_reg = wr; write_data = wd; read_reg1 = r1; read_reg2 = r2;
  endtask

  // Apply one edge: model commits the write, then both acks are checked.
  task automatic edge_and_ack(input string name);
    logic exp_ack;
    exp_ack = reg_write && (write_reg != 5'd0) && !rst;
    @(posedge clk);
    if (!rst && reg_write && write_reg != 5'd0) model_mem[write_reg] = write_data;
    #1;
    chk({name, "_ack_b"}, {31'h0, ack_b}, {31'h0, exp_ack});
    chk({name, "_ack_n"}, {31'h0, ack_n}, {31'h0, exp_ack});
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1_b, exp2_b;
    logic [31:0] exp1_n, exp2_n;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd1_sp", rd1_b, SP_INIT);
    chk("rst_rd2_zero", rd2_b, 32'h0);
    chk("rst_ack", {31'h0, ack_b}, 32'h0);
    chk("rst_rd1_sp_n", rd1_n, SP_INIT);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd0,  32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[1] = '{1'b0, 5'd8,  32'h0,         5'd8,  5'd29, 32'hDEAD_BEEF, SP_INIT, 32'hDEAD_BEEF, SP_INIT, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd8,  32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 5'd31, 32'h0040_0010, 5'd31, 5'd31, 32'h0040_0010, 32'h0040_0010, 32'h0, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 5'd31, 32'h0,         5'd31, 5'd31, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 1'b0};

    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2);
      #1;
      chk($sformatf("vec%0d_rd1_b", v), rd1_b, vecs[v].exp1_b);
      chk($sformatf("vec%0d_rd2_b", v), rd2_b, vecs[v].exp2_b);
      chk($sformatf("vec%0d_rd1_n", v), rd1_n, vecs[v].exp1_n);
      chk($sformatf("vec%0d_rd2_n", v), rd2_n, vecs[v].exp2_n);
      @(posedge clk);
      if (vecs[v].we && vecs[v].wr != 5'd0) model_mem[vecs[v].wr] = vecs[v].wd;
      #1;
      chk($sformatf("vec%0d_ack_b", v), {31'h0, ack_b}, {31'h0, vecs[v].exp_ack});
      chk($sformatf("vec%0d_ack_n", v), {31'h0, ack_n}, {31'h0, vecs[v].exp_ack});
      @(negedge clk);
    end

    // Reset coincident with a write discards the write
    drive(1'b1, 5'd12, 32'h1234_5678, 5'd12, 5'd12);
    edge_and_ack("wr12");
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd29);
    #1;
    chk("wr12_rd_n", rd1_n, 32'h1234_5678);
    @(negedge clk);
    drive(1'b1, 5'd12, 32'hAAAA_AAAA, 5'd12, 5'd12);
    rst = 1'b1;
    #1;
    chk("rstwr_rd1_b", rd1_b, 32'h0);
    chk("rstwr_rd2_n", rd2_n, 32'h0);
    @(posedge clk);
    #1;
    chk("rstwr_ack", {31'h0, ack_b}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd29);
    #1;
    chk("post_rst_r12", rd1_b, 32'h0);
    chk("post_rst_sp", rd2_b, SP_INIT);
    chk("post_rst_sp_n", rd2_n, SP_INIT);

    // Sweep every index, then read complementary pairs
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), {5'(i), 27'h0}, 5'd0, 5'd0);
      edge_and_ack($sformatf("sweep_w%0d", i));
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      e1 = (i == 0) ? 32'h0 : {5'(i), 27'h0};
      e2 = (i == 31) ? 32'h0 : {5'(31 - i), 27'h0};
      #1;
      chk($sformatf("sweep_r1_%0d", i), rd1_b, e1);
      chk($sformatf("sweep_r2_%0d", i), rd2_n, e2);
    end

    // Randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      @(negedge clk);
      wr = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wr, $urandom,
            ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
      #1;
      chk($sformatf("rnd%0d_rd1_b", n), rd1_b, model_read(read_reg1, 1'b1));
      chk($sformatf("rnd%0d_rd2_b", n), rd2_b, model_read(read_reg2, 1'b1));
      chk($sformatf("rnd%0d_rd1_n", n), rd1_n, model_read(read_reg1, 1'b0));
      chk($sformatf("rnd%0d_rd2_n", n), rd2_n, model_read(read_reg2, 1'b0));
      edge_and_ack($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle processor datapath.
- Sits directly downstream of the 5-bit write-destination select (rt / rd / $31). That select's output drives write_reg here.
- Two combinational read ports feed the ALU operand path. One synchronous write port is committed at the clock edge.
- Register $0 is hardwired to zero. $29 (sp) has a programmable reset value.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers).
- SP_INIT, 32'h0000_03FC, reset value of register 29 (stack pointer).
- BYPASS, 1, 1 = write-first forwarding on read ports; 0 = read returns the pre-write value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable, sampled at rising clk.
- write_reg  input  ADDR_WIDTH  destination register index (from the 3:1 destination select).
- write_data  input  DATA_WIDTH  data to write.
- read_reg1  input  ADDR_WIDTH  read port 1 index (rs).
- read_reg2  input  ADDR_WIDTH  read port 2 index (rt).
- read_data1  output  DATA_WIDTH  contents selected by read_reg1.
- read_data2  output  DATA_WIDTH  contents selected by read_reg2.
- write_ack  output  1  registered pulse: high for one cycle after a write that actually modified a register.

Behaviour:
Reset
- rst high, asynchronously and regardless of clk: all registers clear to 0, except reg[29] = SP_INIT.
- write_ack clears to 0.
- Reads while rst is high return the reset contents: 0 for every index except 29.
- Release of rst is synchronised by the next rising edge. The first write can occur at the first rising edge with rst low.

Write
- At rising clk with rst low and reg_write = 1 and write_reg != 0: reg[write_reg] <= write_data; write_ack <= 1.
- reg_write = 1 with write_reg = 0: no state change; write_ack <= 0.
- reg_write = 0: no state change; write_ack <= 0.
- Reset asserted during the same cycle as a write: reset wins and the write is discarded.

Read
- Combinational, zero cycle latency from read_reg* change to read_data*.
- Index 0 always reads 0.
- BYPASS = 1: if reg_write = 1 and write_reg = read_regN and write_reg != 0, read_dataN = write_data in the same cycle.
- BYPASS = 0: read_dataN = stored value; the new value is visible the cycle after the edge.
- Both read ports may select the same index, including the write index; each port bypasses independently.

Width rules
- No arithmetic is performed.
- Indices are unsigned ADDR_WIDTH bits, so all 2^ADDR_WIDTH values are legal. There is no out-of-range case.

State
- No FSM. Sequential state is the register array plus the write_ack flop.

Decomposition:
- Shared package / header `datapath_defs`:
  - DATA_WIDTH, ADDR_WIDTH.
  - Register index constants REG_ZERO = 0, REG_SP = 29, REG_RA = 31.
  - SP_INIT default.
  - The destination select and the decoder use the same constants.
- One natural sub-module, `regbank_read_port`: index decode plus zero-force plus bypass compare. It is instantiated twice.
- Storage and write logic stay in the top module.

Test Plan:
1. Reset: assert rst mid-cycle with no clock edge; read_reg1 = 29, read_reg2 = 5 -> read_data1 = 32'h0000_03FC, read_data2 = 0, write_ack = 0 immediately.
2. Basic write/read: reg_write = 1, write_reg = 8, write_data = 32'hDEAD_BEEF, one edge -> write_ack = 1 for exactly one cycle. Then read_reg1 = 8 -> 32'hDEAD_BEEF, held after reg_write drops.
3. $0 protection: write 32'hFFFF_FFFF to index 0 -> read_data1/2 at index 0 = 0; write_ack stays 0.
4. Bypass: BYPASS = 1, write_reg = read_reg1 = read_reg2 = 31, write_data = 32'h0040_0010, pre-edge -> both read ports show 32'h0040_0010 before the edge. With BYPASS = 0 -> both show the old value until after the edge.
5. Reset mid-operation: write 32'h1234_5678 to reg 12, then assert rst coincident with a write of 32'hAAAA_AAAA to reg 12 -> reg 12 reads 0. After release, reg 29 = SP_INIT.
6. Sweep: write index i with value {i, 27'h0} for i = 1..31, then read all pairs (i, 31-i) -> every value matches; index 0 = 0.
